// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the bus transfer sequencer: sequencer states and
// default bus geometry, reused by the one-hot decoder and by benches.
package bus_xfer_pkg;

    // Default bus geometry: eight agents addressed by a 3-bit index.
    localparam int NUM_AGENTS_DEF = 8;
    localparam int IDX_W_DEF      = 3;

    // Turnaround counter width; covers TURNAROUND values 0..3.
    localparam int TURN_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2,
        TURN  = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/bus_onehot_dec.sv
// Index-to-one-hot decoder for one strobe vector. The output is all-zero when
// the enable is low or when the index does not name an existing agent.
module bus_onehot_dec
    import bus_xfer_pkg::*;
#(
    parameter int NUM_AGENTS = NUM_AGENTS_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic [IDX_W-1:0]      idx,
    input  logic                  en,
    output logic [NUM_AGENTS-1:0] onehot
);

    // Only agents 0..NUM_AGENTS-1 can match, so out-of-range indices decode to zero.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Control-side initiator for the shared tristate DATA bus. One transfer runs
// DRIVE (source on the bus, bus settles) -> LATCH (source still driving,
// destination strobe high) -> TURN (all strobes low for TURNAROUND cycles).
// Every output is a flop fed from the next-state values, so no strobe is a
// combinational function of the request inputs.
// req_ready high means "a command presented now is taken at the next edge";
// it is high in IDLE and also in the last cycle of a transfer, which gives one
// transfer per 2+TURNAROUND cycles when commands are back to back.
// Build option: define BUS_XFER_CHECK_EN to reject commands with src==dst or
// an out-of-range index (consumed with an err pulse, no bus activity).
module bus_xfer_sequencer
    import bus_xfer_pkg::*;
#(
    parameter int NUM_AGENTS = NUM_AGENTS_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int TURNAROUND = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IDX_W-1:0]      req_src,
    input  logic [IDX_W-1:0]      req_dst,
    input  logic                  req_offset,
    output logic [NUM_AGENTS-1:0] out_en,
    output logic [NUM_AGENTS-1:0] in_en,
    output logic [NUM_AGENTS-1:0] offset_in_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Counter preload when entering TURN: it counts down to zero, then IDLE.
    localparam logic [TURN_W-1:0] TURN_LOAD =
        TURN_W'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);

    xfer_state_e       state_q, state_d;
    logic [TURN_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  src_q, src_d;
    logic [IDX_W-1:0]  dst_q, dst_d;
    logic              off_q, off_d;

    logic              accept;
    logic              bad_cmd;
    logic              take;

    logic              drive_en_d;
    logic              latch_en_d;
    logic              ready_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;
    logic [NUM_AGENTS-1:0] out_en_d, in_en_d, offset_in_en_d;

    assign accept = req_valid && req_ready;

`ifdef BUS_XFER_CHECK_EN
    assign bad_cmd = (req_src == req_dst)
                  || (int'(req_src) >= NUM_AGENTS)
                  || (int'(req_dst) >= NUM_AGENTS);
`else
    assign bad_cmd = 1'b0;
`endif

    assign take = accept && !bad_cmd;

    // State register and turnaround counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command fields; they only matter while a transfer is in flight.
    always_ff @(posedge clk) begin
        src_q <= src_d;
        dst_q <= dst_d;
        off_q <= off_d;
    end

    // Next-state logic; an accepted command always restarts at DRIVE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        off_d   = off_q;
        case (state_q)
            IDLE:  state_d = IDLE;
            DRIVE: state_d = LATCH;
            LATCH: begin
                if (TURNAROUND > 0) begin
                    state_d = TURN;
                    cnt_d   = TURN_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = DRIVE;
            src_d   = req_src;
            dst_d   = req_dst;
            off_d   = req_offset;
        end
    end

    // Output decode from the next state, registered below.
    always_comb begin
        drive_en_d = (state_d == DRIVE) || (state_d == LATCH);
        latch_en_d = (state_d == LATCH);
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == LATCH);
        err_d      = accept && bad_cmd;
        ready_d    = (state_d == IDLE)
                  || ((state_d == LATCH) && (TURNAROUND == 0))
                  || ((state_d == TURN) && (cnt_d == '0));
    end

    bus_onehot_dec #(.NUM_AGENTS(NUM_AGENTS), .IDX_W(IDX_W)) u_dec_out (
        .idx    (src_d),
        .en     (drive_en_d),
        .onehot (out_en_d)
    );

    bus_onehot_dec #(.NUM_AGENTS(NUM_AGENTS), .IDX_W(IDX_W)) u_dec_in (
        .idx    (dst_d),
        .en     (latch_en_d && !off_d),
        .onehot (in_en_d)
    );

    bus_onehot_dec #(.NUM_AGENTS(NUM_AGENTS), .IDX_W(IDX_W)) u_dec_off (
        .idx    (dst_d),
        .en     (latch_en_d && off_d),
        .onehot (offset_in_en_d)
    );

    // Output registers; reset clears every strobe immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_en       <= '0;
            in_en        <= '0;
            offset_in_en <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            req_ready    <= 1'b1;
        end else begin
            out_en       <= out_en_d;
            in_en        <= in_en_d;
            offset_in_en <= offset_in_en_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
            req_ready    <= ready_d;
        end
    end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: instance 0 uses TURNAROUND=0, instance 1 uses
// TURNAROUND=1. A timeline model predicts every output from accept times; a
// register-file model on instance 1 follows the bus to check captured data.
module tb_bus_xfer_sequencer;
    import bus_xfer_pkg::*;

    localparam int NA = NUM_AGENTS_DEF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   allow_same = 1'b0;

    logic         req_valid   [2];
    logic [2:0]   req_src     [2];
    logic [2:0]   req_dst     [2];
    logic         req_offset  [2];
    logic         req_ready_w [2];
    logic [NA-1:0] out_en_w   [2];
    logic [NA-1:0] in_en_w    [2];
    logic [NA-1:0] off_en_w   [2];
    logic         busy_w      [2];
    logic         done_w      [2];
    logic         err_w       [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bus_xfer_sequencer #(.NUM_AGENTS(NA), .IDX_W(IDX_W_DEF), .TURNAROUND(g)) dut (
            .clk          (clk),
            .reset        (reset),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready_w[g]),
            .req_src      (req_src[g]),
            .req_dst      (req_dst[g]),
            .req_offset   (req_offset[g]),
            .out_en       (out_en_w[g]),
            .in_en        (in_en_w[g]),
            .offset_in_en (off_en_w[g]),
            .busy         (busy_w[g]),
            .done         (done_w[g]),
            .err          (err_w[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d got %h want %h", name, g, cyc, act, exp);
        end
    endtask

    // Agent register file on instance 1's bus, plus a preload port for stimulus.
    logic [15:0] regs [NA];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = '0;
    logic [15:0] pl_val = '0;

    always @(posedge clk) begin
        logic [15:0] bus;
        bus = '0;
        for (int i = 0; i < NA; i++) if (out_en_w[1][i]) bus = bus | regs[i];
        for (int i = 0; i < NA; i++) begin
            if (in_en_w[1][i]) regs[i] = bus;
            else if (off_en_w[1][i]) regs[i] = {{7{bus[8]}}, bus[8:0]};
        end
        if (pl_en) regs[pl_idx] = pl_val;
    end

    // Timeline model: one record per instance for the latest started transfer.
    bit         have [2];
    int         a_m  [2];
    logic [2:0] s_m  [2];
    logic [2:0] d_m  [2];
    logic       o_m  [2];
    int         dn0  [2];
    int         dn1  [2];
    int         er   [2];

    initial begin
        for (int g = 0; g < 2; g++) begin
            have[g] = 0; a_m[g] = -100; dn0[g] = -100; dn1[g] = -100; er[g] = -100;
            s_m[g] = '0; d_m[g] = '0; o_m[g] = 1'b0;
        end
    end

    always @(negedge clk) begin
        int c, t;
        bit act, lat, bad, e_rdy;
        logic [NA-1:0] e_out, e_in, e_off, cap;
        c = cyc;
        for (int g = 0; g < 2; g++) begin
            t = g;
            if (!reset) begin
                have[g] = 0; dn0[g] = -100; dn1[g] = -100; er[g] = -100;
            end else begin
                act   = have[g] && (c >= a_m[g]) && (c <= a_m[g] + 1);
                lat   = have[g] && (c == a_m[g] + 1);
                e_out = act ? (NA'(1) << s_m[g]) : '0;
                e_in  = (lat && !o_m[g]) ? (NA'(1) << d_m[g]) : '0;
                e_off = (lat && o_m[g]) ? (NA'(1) << d_m[g]) : '0;
                e_rdy = !have[g] || (c + 1 >= a_m[g] + 2 + t);
                chk("out_en", g, 32'(out_en_w[g]), 32'(e_out));
                chk("in_en", g, 32'(in_en_w[g]), 32'(e_in));
                chk("offset_in_en", g, 32'(off_en_w[g]), 32'(e_off));
                chk("busy", g, 32'(busy_w[g]), 32'(have[g] && (c >= a_m[g]) && (c <= a_m[g] + 1 + t)));
                chk("done", g, 32'(done_w[g]), 32'((c == dn0[g]) || (c == dn1[g])));
                chk("err", g, 32'(err_w[g]), 32'(c == er[g]));
                chk("req_ready", g, 32'(req_ready_w[g]), 32'(e_rdy));
                // Bus-level invariants, independent of the timeline.
                cap = in_en_w[g] | off_en_w[g];
                chk("one_driver", g, 32'($countones(out_en_w[g]) <= 1), 32'd1);
                chk("one_capture", g, 32'($countones(cap) <= 1), 32'd1);
                if (cap != '0) begin
                    chk("capture_needs_driver", g, 32'((out_en_w[g] != '0) &&
                        (allow_same || ((out_en_w[g] & cap) == '0))), 32'd1);
                end
`ifdef BUS_XFER_CHECK_EN
                bad = (req_src[g] == req_dst[g]) || (int'(req_src[g]) >= NA) || (int'(req_dst[g]) >= NA);
`else
                bad = 1'b0;
`endif
                if (req_valid[g] && e_rdy) begin
                    if (bad) begin
                        er[g] = c + 1;
                    end else begin
                        have[g] = 1; a_m[g] = c + 1;
                        s_m[g] = req_src[g]; d_m[g] = req_dst[g]; o_m[g] = req_offset[g];
                        dn0[g] = dn1[g]; dn1[g] = c + 3;
                    end
                end
            end
        end
    end

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Present a command and hold it until taken; returns the accept edge index.
    task automatic send(input int g, input logic [2:0] s, input logic [2:0] d, input logic o, output int acc);
        bit ok;
        int n;
        ok = 0; n = 0;
        req_valid[g] = 1'b1; req_src[g] = s; req_dst[g] = d; req_offset[g] = o;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = req_ready_w[g];
            @(posedge clk); #1;
            n++;
        end
        chk("accept_within_bound", g, 32'(ok), 32'd1);
        acc = cyc;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2, a3;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0; req_src[g] = '0; req_dst[g] = '0; req_offset[g] = 1'b0;
        end
        for (int i = 0; i < NA; i++) regs[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Idle after reset release.
        @(negedge clk);
        chk("reset_ready", 1, 32'(req_ready_w[1]), 32'd1);
        chk("reset_out_en", 1, 32'(out_en_w[1]), 32'd0);
        chk("reset_busy", 0, 32'(busy_w[0]), 32'd0);
        @(posedge clk); #1;

        // src=2 -> dst=5, full-width capture.
        preload(3'd2, 16'h1234);
        send(1, 3'd2, 3'd5, 1'b0, a);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t1_drive_out", 1, 32'(out_en_w[1]), 32'b0000_0100);
        chk("t1_drive_in", 1, 32'(in_en_w[1]), 32'd0);
        @(negedge clk);
        chk("t1_latch_out", 1, 32'(out_en_w[1]), 32'b0000_0100);
        chk("t1_latch_in", 1, 32'(in_en_w[1]), 32'b0010_0000);
        @(negedge clk);
        chk("t1_done", 1, 32'(done_w[1]), 32'd1);
        chk("t1_out_off", 1, 32'(out_en_w[1]), 32'd0);
        chk("t1_data", 1, 32'(regs[5]), 32'h1234);
        idle_cycles(3);

        // src=3 -> dst=1 through the offset strobe.
        preload(3'd3, 16'h0180);
        preload(3'd1, 16'h0000);
        send(1, 3'd3, 3'd1, 1'b1, a);
        req_valid[1] = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t2_offset_en", 1, 32'(off_en_w[1]), 32'b0000_0010);
        chk("t2_in_en", 1, 32'(in_en_w[1]), 32'd0);
        @(negedge clk);
        chk("t2_data", 1, 32'(regs[1]), 32'hFF80);
        idle_cycles(3);

        // Back-to-back, TURNAROUND=1.
        send(1, 3'd0, 3'd1, 1'b0, a1);
        send(1, 3'd1, 3'd2, 1'b1, a2);
        send(1, 3'd2, 3'd3, 1'b0, a3);
        req_valid[1] = 1'b0;
        chk("t3_space_a", 1, 32'(a2 - a1), 32'd3);
        chk("t3_space_b", 1, 32'(a3 - a2), 32'd3);
        idle_cycles(5);

        // Back-to-back, TURNAROUND=0.
        send(0, 3'd4, 3'd5, 1'b0, a1);
        send(0, 3'd5, 3'd6, 1'b0, a2);
        send(0, 3'd6, 3'd7, 1'b1, a3);
        req_valid[0] = 1'b0;
        chk("t4_space_a", 0, 32'(a2 - a1), 32'd2);
        chk("t4_space_b", 0, 32'(a3 - a2), 32'd2);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("t4_done", 0, 32'(done_w[0]), 32'd1);
        chk("t4_ready_with_done", 0, 32'(req_ready_w[0]), 32'd1);
        idle_cycles(4);

        // Reset asserted during LATCH.
        preload(3'd6, 16'hBEEF);
        preload(3'd7, 16'h0000);
        send(1, 3'd6, 3'd7, 1'b0, a);
        req_valid[1] = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t5_latch_in", 1, 32'(in_en_w[1]), 32'b1000_0000);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_out", 1, 32'(out_en_w[1]), 32'd0);
        chk("t5_rst_in", 1, 32'(in_en_w[1]), 32'd0);
        chk("t5_rst_busy", 1, 32'(busy_w[1]), 32'd0);
        chk("t5_rst_done", 1, 32'(done_w[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t5_no_capture", 1, 32'(regs[7]), 32'h0000);
        chk("t5_ready", 1, 32'(req_ready_w[1]), 32'd1);
        @(posedge clk); #1;
        preload(3'd0, 16'h5A5A);
        send(1, 3'd0, 3'd7, 1'b0, a);
        req_valid[1] = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("t5_after_done", 1, 32'(done_w[1]), 32'd1);
        chk("t5_after_data", 1, 32'(regs[7]), 32'h5A5A);
        idle_cycles(3);

        // src == dst.
        allow_same = 1'b1;
        send(1, 3'd4, 3'd4, 1'b0, a);
        req_valid[1] = 1'b0;
        @(negedge clk);
`ifdef BUS_XFER_CHECK_EN
        chk("t6_err", 1, 32'(err_w[1]), 32'd1);
        chk("t6_no_strobe", 1, 32'(out_en_w[1]), 32'd0);
        chk("t6_not_busy", 1, 32'(busy_w[1]), 32'd0);
        @(negedge clk);
        chk("t6_err_once", 1, 32'(err_w[1]), 32'd0);
        @(negedge clk);
        chk("t6_no_done", 1, 32'(done_w[1]), 32'd0);
`else
        chk("t6_no_err", 1, 32'(err_w[1]), 32'd0);
        chk("t6_drive", 1, 32'(out_en_w[1]), 32'b0001_0000);
        @(negedge clk); @(negedge clk);
        chk("t6_done", 1, 32'(done_w[1]), 32'd1);
`endif
        idle_cycles(4);
        allow_same = 1'b0;

        // Random stream of 200 commands across both instances.
        for (int k = 0; k < 200; k++) begin
            int g;
            logic [2:0] s, d;
            g = k % 2;
            s = 3'($urandom_range(0, NA - 1));
            d = 3'($urandom_range(0, NA - 2));
            if (d >= s) d = d + 3'd1;
            send(g, s, d, 1'($urandom_range(0, 1)), a);
            if ($urandom_range(0, 2) == 0) begin
                req_valid[g] = 1'b0;
                idle_cycles($urandom_range(1, 3));
            end else begin
                req_valid[g] = 1'b0;
            end
        end
        idle_cycles(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
